// File: rtl/keypad_scanner_if.sv
// Pin-side and decoder-side signals of the 4x4 keypad scanner.
// The slave modport is the scanner itself; the master modport is the keypad/consumer side.
`timescale 1ns/1ps
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic       key_valid;
  logic       key_down;

  modport master (
    output row_in,
    input  col_out,
    input  row_idx,
    input  col_idx,
    input  key_valid,
    input  key_down
  );

  modport slave (
    input  row_in,
    output col_out,
    output row_idx,
    output col_idx,
    output key_valid,
    output key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, synchronises and
// debounces the row lines, and reports the accepted key as 2-bit row/column indices.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_CNT     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.slave kp
);

  localparam int CNT_MAX = (SCAN_CNT > DEBOUNCE_CNT) ? SCAN_CNT : DEBOUNCE_CNT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CNT - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  function automatic logic [3:0] col_mask(input logic [1:0] c);
    col_mask = ~(4'b0001 << c);
  endfunction

  // Lowest-index active (low) row wins when several rows are low together.
  function automatic logic [1:0] lowest_zero(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  state_t          state, state_n;
  logic [1:0]      column, column_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      sync_a, row_sync;
  logic [1:0]      row_lat, row_lat_n;
  logic [1:0]      col_lat, col_lat_n;
  logic [3:0]      col_drive, col_drive_n;
  logic [1:0]      row_idx, row_idx_n;
  logic [1:0]      col_idx, col_idx_n;
  logic            key_valid, key_valid_n;
  logic            key_down, key_down_n;
  logic            key_bit;

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a   <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      sync_a   <= kp.row_in;
      row_sync <= sync_a;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      column    <= 2'd0;
      cnt       <= '0;
      row_lat   <= 2'd0;
      col_lat   <= 2'd0;
      col_drive <= 4'b1110;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      column    <= column_n;
      cnt       <= cnt_n;
      row_lat   <= row_lat_n;
      col_lat   <= col_lat_n;
      col_drive <= col_drive_n;
      row_idx   <= row_idx_n;
      col_idx   <= col_idx_n;
      key_valid <= key_valid_n;
      key_down  <= key_down_n;
    end
  end

  // Next-state and next-output logic; col_drive_n always tracks the column that
  // will be driven after this edge so col_out stays registered.
  always_comb begin
    state_n     = state;
    column_n    = column;
    cnt_n       = cnt;
    row_lat_n   = row_lat;
    col_lat_n   = col_lat;
    col_drive_n = col_drive;
    row_idx_n   = row_idx;
    col_idx_n   = col_idx;
    key_valid_n = 1'b0;
    key_down_n  = key_down;
    key_bit     = row_sync[row_lat];

    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_n = '0;
          if (row_sync != 4'b1111) begin
            row_lat_n   = lowest_zero(row_sync);
            col_lat_n   = column;
            col_drive_n = col_mask(column);
            state_n     = DEBOUNCE;
          end else begin
            column_n    = column + 2'd1;
            col_drive_n = col_mask(column + 2'd1);
          end
        end else begin
          cnt_n       = cnt + CNT_ONE;
          col_drive_n = col_mask(column);
        end
      end

      DEBOUNCE: begin
        if (!key_bit) begin
          if (cnt == DEB_LAST) begin
            row_idx_n   = row_lat;
            col_idx_n   = col_lat;
            key_valid_n = 1'b1;
            key_down_n  = 1'b1;
            cnt_n       = '0;
            state_n     = HELD;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else begin
          column_n    = col_lat + 2'd1;
          col_drive_n = col_mask(col_lat + 2'd1);
          cnt_n       = '0;
          state_n     = SCAN;
        end
      end

      HELD: begin
        // Only the latched row is watched here; counter tracks consecutive released cycles.
        if (key_bit) begin
          if (cnt == DEB_LAST) begin
            key_down_n  = 1'b0;
            column_n    = col_lat + 2'd1;
            col_drive_n = col_mask(col_lat + 2'd1);
            cnt_n       = '0;
            state_n     = SCAN;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else begin
          cnt_n = '0;
        end
      end

      default: begin
        state_n     = SCAN;
        column_n    = 2'd0;
        cnt_n       = '0;
        col_drive_n = 4'b1110;
        key_down_n  = 1'b0;
      end
    endcase
  end

  assign kp.col_out   = col_drive;
  assign kp.row_idx   = row_idx;
  assign kp.col_idx   = col_idx;
  assign kp.key_valid = key_valid;
  assign kp.key_down  = key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad and a
// scoreboard of expected accepted keys popped on every key_valid pulse.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_CNT(4), .DEBOUNCE_CNT(8)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // Keypad model: keys[r*4+c] pressed pulls row r low while column c is driven low.
  logic [15:0] keys = 16'h0000;
  logic [3:0]  row_model;
  always_comb begin
    row_model = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (kp.col_out[c] === 1'b0)) row_model[r] = 1'b0;
      end
    end
  end
  assign kp.row_in = row_model;

  typedef struct { int row; int col; } exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct { int r0; int c0; int r1; int c1; int er; int ec; } vec_t;
  vec_t vecs[4];

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int falls    = 0;
  bit prev_valid = 1'b0;
  bit prev_down  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mask_of(input int c);
    logic [3:0] m;
    m = ~(4'b0001 << c[1:0]);
    return m;
  endfunction

  // Scoreboard monitor: every key_valid pops one expected key.
  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      pulses++;
      check("expected_pending", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("row_idx", kp.row_idx, e.row);
        check("col_idx", kp.col_idx, e.col);
        check("key_down_at_valid", kp.key_down, 1);
      end
      check("key_valid_width", prev_valid, 0);
    end
    if (prev_down && (kp.key_down === 1'b0)) falls++;
    prev_valid = (kp.key_valid === 1'b1);
    prev_down  = (kp.key_down === 1'b1);
  end

  task automatic wait_down(input logic lvl, input int bound, input string name);
    int n = 0;
    while ((kp.key_down !== lvl) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check(name, kp.key_down, lvl);
  endtask

  task automatic wait_col(input logic [3:0] col, input int bound, input string name);
    int n = 0;
    while ((kp.col_out !== col) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check(name, kp.col_out, col);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0;
    logic [3:0] exp_col;

    vecs[0] = '{2, 1, -1, 0, 2, 1};
    vecs[1] = '{1, 2,  3, 2, 1, 2};
    vecs[2] = '{0, 0, -1, 0, 0, 0};
    vecs[3] = '{3, 3,  2, 3, 2, 3};

    // Reset values, then idle scan with each column held four cycles.
    repeat (3) @(negedge clk);
    check("rst_col_out", kp.col_out, 4'b1110);
    check("rst_row_idx", kp.row_idx, 0);
    check("rst_col_idx", kp.col_idx, 0);
    check("rst_key_valid", kp.key_valid, 0);
    check("rst_key_down", kp.key_down, 0);
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      exp_col = mask_of((k / 4) % 4);
      check("idle_col_out", kp.col_out, exp_col);
      check("idle_key_valid", kp.key_valid, 0);
      check("idle_key_down", kp.key_down, 0);
    end

    // Clean presses from the vector table, exact release timing and scan resume column.
    for (int i = 0; i < 4; i++) begin
      p0 = pulses;
      keys = 16'h0000;
      keys[vecs[i].r0*4 + vecs[i].c0] = 1'b1;
      if (vecs[i].r1 >= 0) keys[vecs[i].r1*4 + vecs[i].c1] = 1'b1;
      sb.push_back('{vecs[i].er, vecs[i].ec});
      repeat (40) @(negedge clk);
      check("held_key_down", kp.key_down, 1);
      keys = 16'h0000;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        check("release_key_down", kp.key_down, (k < 10));
      end
      exp_col = mask_of((vecs[i].ec + 1) % 4);
      check("resume_col_out", kp.col_out, exp_col);
      check("vec_pulse_count", pulses - p0, 1);
      check("vec_sb_empty", sb.size(), 0);
    end

    // Bounce on (0,3) must not be accepted; a later clean press is.
    do_reset();
    p0 = pulses;
    wait_col(4'b0111, 40, "bounce_reach_col3");
    keys[3] = 1'b1; repeat (3) @(negedge clk);
    keys[3] = 1'b0; repeat (2) @(negedge clk);
    keys[3] = 1'b1; repeat (3) @(negedge clk);
    keys[3] = 1'b0; repeat (60) @(negedge clk);
    check("bounce_no_pulse", pulses - p0, 0);
    check("bounce_key_down", kp.key_down, 0);
    check("bounce_row_idx", kp.row_idx, 0);
    check("bounce_col_idx", kp.col_idx, 0);
    sb.push_back('{0, 3});
    keys[3] = 1'b1;
    repeat (40) @(negedge clk);
    check("clean03_key_down", kp.key_down, 1);
    keys = 16'h0000;
    wait_down(1'b0, 15, "clean03_release");
    check("clean03_pulse_count", pulses - p0, 1);
    check("clean03_sb_empty", sb.size(), 0);

    // Reset while HELD on (3,0): immediate reset values, then re-acceptance.
    do_reset();
    keys[12] = 1'b1;
    sb.push_back('{3, 0});
    wait_down(1'b1, 60, "held30_accept");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_col_out", kp.col_out, 4'b1110);
    check("midrst_key_down", kp.key_down, 0);
    check("midrst_key_valid", kp.key_valid, 0);
    check("midrst_row_idx", kp.row_idx, 0);
    check("midrst_col_idx", kp.col_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{3, 0});
    wait_down(1'b1, 60, "reaccept30");
    check("reaccept_row_idx", kp.row_idx, 3);
    check("reaccept_col_idx", kp.col_idx, 0);
    keys = 16'h0000;
    wait_down(1'b0, 15, "reaccept30_release");
    check("reaccept_sb_empty", sb.size(), 0);

    // Release glitch while HELD on (2,2): key_down stays high, one pulse, one fall.
    do_reset();
    p0 = pulses;
    f0 = falls;
    keys[10] = 1'b1;
    sb.push_back('{2, 2});
    wait_down(1'b1, 60, "glitch_accept");
    repeat (5) @(negedge clk);
    keys[10] = 1'b0; repeat (3) @(negedge clk);
    keys[10] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("glitch_key_down", kp.key_down, 1);
    end
    keys = 16'h0000;
    wait_down(1'b0, 15, "glitch_release");
    repeat (20) @(negedge clk);
    check("glitch_after_key_down", kp.key_down, 0);
    check("glitch_pulse_count", pulses - p0, 1);
    check("glitch_fall_count", falls - f0, 1);
    check("glitch_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
